// File: rtl/bf16_exp_table_ctrl_if.sv
// Coefficient-load, cfg-write, evaluation and MAC-operand signal bundle for bf16_exp_table_ctrl.
// master = coefficient source / compute front end / MAC side, slave = the controller.
interface bf16_exp_table_ctrl_if #(
   parameter int BASE_W = 16,
   parameter int OFF_W  = 26
);
   logic              ld_start;
   logic              ld_valid;
   logic              ld_ready;
   logic [BASE_W-1:0] ld_base;
   logic [OFF_W-1:0]  ld_offset;
   logic              table_valid;
   logic              busy;
   logic              cfg_w_en;
   logic              cfg_sgn;
   logic [3:0]        cfg_idx;
   logic [BASE_W-1:0] cfg_base;
   logic [OFF_W-1:0]  cfg_offset;
   logic              req_valid;
   logic              req_ready;
   logic [15:0]       req_x;
   logic [15:0]       mac_x;
   logic [15:0]       mac_y;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [15:0]       rsp_y;

   modport master (
      output ld_start, ld_valid, ld_base, ld_offset, req_valid, req_x, mac_y, rsp_ready,
      input  ld_ready, table_valid, busy, cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset,
             req_ready, mac_x, rsp_valid, rsp_y
   );

   modport slave (
      input  ld_start, ld_valid, ld_base, ld_offset, req_valid, req_x, mac_y, rsp_ready,
      output ld_ready, table_valid, busy, cfg_w_en, cfg_sgn, cfg_idx, cfg_base, cfg_offset,
             req_ready, mac_x, rsp_valid, rsp_y
   );
endinterface

// File: rtl/bf16_exp_table_ctrl.sv
// Table-load sequencer and gated two-stage evaluation pipeline for the BF16 piecewise-linear exp MAC.
// Optional EXP_CTRL_PERF_EN adds a saturating eval_count output of consumed responses.
module bf16_exp_table_ctrl #(
   parameter int NUM_SEG = 13,
   parameter int BASE_W  = 16,
   parameter int OFF_W   = 26
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bf16_exp_table_ctrl_if.slave bus
`ifdef EXP_CTRL_PERF_EN
   ,
   output logic [31:0]          eval_count
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_DRAIN = 2'd1,
      ST_LOAD  = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_SEG - 1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic              seg_sgn_r;
   logic [3:0]        seg_idx_r;
   logic              beat_s;
   logic              last_beat_s;
   logic              adv_s;
   logic              req_ready_s;
   logic              req_acc_s;
   logic              pipe_busy_s;
   logic              xv_r;
   logic              rsp_valid_r;
   logic [15:0]       mac_x_r;
   logic [15:0]       rsp_y_r;
   logic              cfg_w_en_r;
   logic              cfg_sgn_r;
   logic [3:0]        cfg_idx_r;
   logic [BASE_W-1:0] cfg_base_r;
   logic [OFF_W-1:0]  cfg_offset_r;

   // Handshake qualifiers and next-state selection
   always_comb begin
      adv_s       = !rsp_valid_r || bus.rsp_ready;
      req_ready_s = (state_r == ST_RUN) && (!xv_r || adv_s);
      req_acc_s   = bus.req_valid && req_ready_s;
      beat_s      = (state_r == ST_LOAD) && bus.ld_valid;
      last_beat_s = beat_s && seg_sgn_r && (seg_idx_r == LAST_IDX);
      // A request accepted alongside ld_start must also drain before the table is rewritten
      pipe_busy_s = xv_r || rsp_valid_r || req_acc_s;
      state_nxt_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (bus.ld_start) state_nxt_s = ST_LOAD;
            else              state_nxt_s = ST_EMPTY;
         end
         ST_RUN: begin
            if (bus.ld_start) state_nxt_s = pipe_busy_s ? ST_DRAIN : ST_LOAD;
            else              state_nxt_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (!xv_r && !rsp_valid_r) state_nxt_s = ST_LOAD;
            else                       state_nxt_s = ST_DRAIN;
         end
         ST_LOAD: begin
            if (last_beat_s) state_nxt_s = ST_RUN;
            else             state_nxt_s = ST_LOAD;
         end
         default: state_nxt_s = ST_EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_r <= ST_EMPTY;
      else        state_r <= state_nxt_s;
   end

   // Entry counter: sgn 0 idx 0..NUM_SEG-1, then sgn 1; parked at zero outside LOAD
   always_ff @(posedge clk) begin
      if (!rst_n || (state_r != ST_LOAD)) begin
         seg_sgn_r <= 1'b0;
         seg_idx_r <= 4'd0;
      end else if (beat_s) begin
         if (seg_idx_r == LAST_IDX) begin
            seg_sgn_r <= ~seg_sgn_r;
            seg_idx_r <= 4'd0;
         end else begin
            seg_idx_r <= seg_idx_r + 4'd1;
         end
      end
   end

   // Registered cfg write port; data holds between writes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_w_en_r   <= 1'b0;
         cfg_sgn_r    <= 1'b0;
         cfg_idx_r    <= 4'd0;
         cfg_base_r   <= '0;
         cfg_offset_r <= '0;
      end else if (beat_s) begin
         cfg_w_en_r   <= 1'b1;
         cfg_sgn_r    <= seg_sgn_r;
         cfg_idx_r    <= seg_idx_r;
         cfg_base_r   <= bus.ld_base;
         cfg_offset_r <= bus.ld_offset;
      end else begin
         cfg_w_en_r   <= 1'b0;
      end
   end

   // x stage and result stage of the evaluation pipeline
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xv_r        <= 1'b0;
         mac_x_r     <= 16'h0000;
         rsp_valid_r <= 1'b0;
         rsp_y_r     <= 16'h0000;
      end else begin
         if (req_acc_s) begin
            mac_x_r <= bus.req_x;
            xv_r    <= 1'b1;
         end else if (adv_s) begin
            xv_r    <= 1'b0;
         end
         if (xv_r && adv_s) begin
            rsp_y_r     <= bus.mac_y;
            rsp_valid_r <= 1'b1;
         end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
         end
      end
   end

`ifdef EXP_CTRL_PERF_EN
   logic [31:0] eval_count_r;

   // Saturating count of consumed responses, cleared on each table reload
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         eval_count_r <= 32'd0;
      end else if ((state_nxt_s == ST_LOAD) && (state_r != ST_LOAD)) begin
         eval_count_r <= 32'd0;
      end else if (rsp_valid_r && bus.rsp_ready && (eval_count_r != 32'hFFFF_FFFF)) begin
         eval_count_r <= eval_count_r + 32'd1;
      end
   end

   assign eval_count = eval_count_r;
`else
   // No performance counter in this build
`endif

   assign bus.ld_ready    = (state_r == ST_LOAD);
   assign bus.table_valid = (state_r == ST_RUN);
   assign bus.busy        = (state_r == ST_DRAIN) || (state_r == ST_LOAD);
   assign bus.req_ready   = req_ready_s;
   assign bus.mac_x       = mac_x_r;
   assign bus.rsp_valid   = rsp_valid_r;
   assign bus.rsp_y       = rsp_y_r;
   assign bus.cfg_w_en    = cfg_w_en_r;
   assign bus.cfg_sgn     = cfg_sgn_r;
   assign bus.cfg_idx     = cfg_idx_r;
   assign bus.cfg_base    = cfg_base_r;
   assign bus.cfg_offset  = cfg_offset_r;

endmodule
